// File: rtl/xunit_msched.sv
// SHA-256 message schedule: loads 16 words on in0, then expands W16..W(NWORDS-1), one word per cycle; out0 registered (1 cycle).
// No backpressure: running=0 freezes LOAD/EXPAND; run restarts from any state; done is high in IDLE/FIN.
module xunit_msched #(
    parameter int DELAY_W = 32,
    parameter int DATA_W  = 32,
    parameter int NWORDS  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               running,
    input  logic               run,
    output logic               done,
    input  logic [DATA_W-1:0]  in0,
    output logic [DATA_W-1:0]  out0,
    input  logic [DELAY_W-1:0] delay0
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_EXPAND,
        S_FIN
    } state_t;

    localparam logic [6:0] LAST_LOAD = 7'd15;
    localparam logic [6:0] LAST_WORD = 7'(NWORDS - 1);

    state_t              state_q, state_d;
    logic [DELAY_W-1:0]  delay_q, delay_d;
    logic [6:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   out0_q, out0_d;
    logic [DATA_W-1:0]   win_q [16];
    logic [DATA_W-1:0]   win_d [16];
    logic [DATA_W-1:0]   w_exp;
    logic [DATA_W-1:0]   shift_dat;
    logic                shift_en;

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
        return (x >> n) | (x << (DATA_W - n));
    endfunction

    function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // win[k] holds W_(t-1-k) when computing W_t
    assign w_exp = sig1(win_q[1]) + win_q[6] + sig0(win_q[14]) + win_q[15];

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        cnt_d     = cnt_q;
        out0_d    = out0_q;
        shift_en  = 1'b0;
        shift_dat = in0;
        if (run) begin
            state_d = S_WAIT;
            delay_d = delay0;
            cnt_d   = 7'd0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (delay_q == '0) begin
                        state_d = S_LOAD;
                    end else begin
                        delay_d = delay_q - DELAY_W'(1);
                    end
                end
                S_LOAD: begin
                    if (running) begin
                        shift_en  = 1'b1;
                        shift_dat = in0;
                        cnt_d     = cnt_q + 7'd1;
                        if (cnt_q == LAST_LOAD) state_d = S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    if (running) begin
                        shift_en  = 1'b1;
                        shift_dat = w_exp;
                        cnt_d     = cnt_q + 7'd1;
                        if (cnt_q == LAST_WORD) state_d = S_FIN;
                    end
                end
                default: ;
            endcase
        end
        if (shift_en) out0_d = shift_dat;
    end

    always_comb begin
        for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
        if (shift_en) begin
            for (int i = 15; i > 0; i--) win_d[i] = win_q[i-1];
            win_d[0] = shift_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            delay_q <= '0;
            cnt_q   <= 7'd0;
            out0_q  <= '0;
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            cnt_q   <= cnt_d;
            out0_q  <= out0_d;
            for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
        end
    end

    assign out0 = out0_q;
    assign done = (state_q == S_IDLE) || (state_q == S_FIN);

endmodule

// File: tb/tb_xunit_msched.sv
// Bench for xunit_msched: per-cycle comparison against an indexed-array schedule model plus directed literal checks.
module tb_xunit_msched;

    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] w64_t [64];

    logic        clk = 1'b0;
    logic        rst;
    logic        running;
    logic        run;
    logic        done;
    logic [31:0] in0;
    logic [31:0] out0;
    logic [31:0] delay0;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    logic [31:0] log_out [4096];
    logic        log_done [4096];

    xunit_msched #(.DELAY_W(32), .DATA_W(32), .NWORDS(64)) dut (
        .clk    (clk),
        .rst    (rst),
        .running(running),
        .run    (run),
        .done   (done),
        .in0    (in0),
        .out0   (out0),
        .delay0 (delay0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bs0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] bs1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic sw_sched(input blk_t m, output w64_t w);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else w[t] = bs1(w[t-2]) + w[t-7] + bs0(w[t-15]) + w[t-16];
        end
    endtask

    // Reference model: tracks the block position t and the words produced so far
    logic [31:0] m_w [64];
    logic [31:0] m_out  = '0;
    bit          m_wait = 1'b0;
    bit          m_busy = 1'b0;
    int          m_dly  = 0;
    int          m_t    = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_wait = 1'b0;
            m_busy = 1'b0;
            m_t    = 0;
            m_out  = '0;
        end else if (run) begin
            m_wait = 1'b1;
            m_busy = 1'b0;
            m_dly  = int'(delay0);
            m_t    = 0;
        end else if (m_wait) begin
            if (m_dly == 0) begin
                m_wait = 1'b0;
                m_busy = 1'b1;
            end else begin
                m_dly--;
            end
        end else if (m_busy && running) begin
            if (m_t < 16) m_w[m_t] = in0;
            else m_w[m_t] = bs1(m_w[m_t-2]) + m_w[m_t-7] + bs0(m_w[m_t-15]) + m_w[m_t-16];
            m_out = m_w[m_t];
            m_t++;
            if (m_t == 64) m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cyc < 4096) begin
            log_out[cyc]  = out0;
            log_done[cyc] = done;
        end
        if (chk_en) begin
            check("out0_vs_model", out0, m_out);
            check("done_vs_model", {31'b0, done}, {31'b0, !(m_wait || m_busy)});
        end
    end

    // Starts at a negedge: pulses run, feeds the block, optional stall; returns early when t reaches stop_at.
    task automatic drive_block(input blk_t m, input int d, input int stall_at, input int stall_len,
                               input int stop_at, output int r);
        int t_drv;
        int stall_left;
        int post;
        t_drv      = 0;
        stall_left = stall_len;
        post       = 0;
        r          = cyc;
        run        = 1'b1;
        delay0     = 32'(d);
        running    = 1'($urandom);
        in0        = $urandom;
        @(negedge clk);
        run    = 1'b0;
        delay0 = $urandom_range(0, 50);
        for (int k = 1; k < 300; k++) begin
            if (t_drv == stop_at || post >= 4) break;
            if (k < d + 2) begin
                running = 1'($urandom);
                in0     = $urandom;
            end else if (t_drv < 64) begin
                if (t_drv == stall_at && stall_left > 0) begin
                    running = 1'b0;
                    in0     = $urandom;
                    stall_left--;
                end else begin
                    running = 1'b1;
                    in0     = (t_drv < 16) ? m[t_drv] : $urandom;
                    t_drv++;
                end
            end else begin
                running = 1'($urandom);
                in0     = $urandom;
                post++;
            end
            @(negedge clk);
        end
    endtask

    blk_t abc, zero, ones, mix;
    w64_t w_abc, w_zero, w_ones, w_mix;
    int   r;

    initial begin
        rst     = 1'b1;
        run     = 1'b0;
        running = 1'b0;
        in0     = '0;
        delay0  = '0;
        for (int i = 0; i < 16; i++) begin
            abc[i]  = '0;
            zero[i] = '0;
            ones[i] = 32'hFFFF_FFFF;
            mix[i]  = 32'(i + 1) * 32'h9E37_79B9;
        end
        abc[0]  = 32'h6162_6380;
        abc[15] = 32'h0000_0018;
        sw_sched(abc, w_abc);
        sw_sched(zero, w_zero);
        sw_sched(ones, w_ones);
        sw_sched(mix, w_mix);

        check("sw_abc_w16", w_abc[16], 32'h6162_6380);
        check("sw_abc_w17", w_abc[17], 32'h000F_0000);
        check("sw_abc_w63", w_abc[63], 32'h12B1_EDEB);
        check("sw_ones_w16", w_ones[16], 32'h203F_FFFC);

        // Reset
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("rst_out0", out0, 32'h0);
        check("rst_done", {31'b0, done}, 32'h1);
        repeat (5) begin
            @(negedge clk);
            in0     = $urandom;
            running = 1'($urandom);
        end
        check("idle_out0", out0, 32'h0);
        check("idle_done", {31'b0, done}, 32'h1);

        // "abc" block, no delay
        drive_block(abc, 0, -1, 0, -1, r);
        for (int t = 0; t < 64; t++) check("abc_word", log_out[r+3+t], w_abc[t]);
        check("abc_w16", log_out[r+19], 32'h6162_6380);
        check("abc_w17", log_out[r+20], 32'h000F_0000);
        check("abc_w63", log_out[r+66], 32'h12B1_EDEB);
        check("abc_done_r1", {31'b0, log_done[r+1]}, 32'h0);
        check("abc_done_r65", {31'b0, log_done[r+65]}, 32'h0);
        check("abc_done_r67", {31'b0, log_done[r+67]}, 32'h1);
        check("abc_hold_r67", log_out[r+67], 32'h12B1_EDEB);

        // Delay alignment
        drive_block(mix, 3, -1, 0, -1, r);
        for (int k = 1; k <= 4; k++) check("dly_done_low", {31'b0, log_done[r+k]}, 32'h0);
        check("dly_m0", log_out[r+6], mix[0]);
        check("dly_w63", log_out[r+69], w_mix[63]);

        // Stall of 4 cycles at t=20
        drive_block(abc, 0, 20, 4, -1, r);
        for (int k = 22; k <= 26; k++) check("stall_hold_w19", log_out[r+k], w_abc[19]);
        check("stall_w20", log_out[r+27], w_abc[20]);
        check("stall_w63", log_out[r+70], 32'h12B1_EDEB);

        // Restart at t=40 with an all-zero block
        drive_block(abc, 0, -1, 0, 40, r);
        drive_block(zero, 0, -1, 0, -1, r);
        check("restart_hold", log_out[r+1], w_abc[39]);
        for (int t = 0; t < 64; t++) check("zero_word", log_out[r+3+t], w_zero[t]);

        // Reset at t=30
        drive_block(abc, 0, -1, 0, 30, r);
        rst     = 1'b1;
        running = 1'b1;
        in0     = $urandom;
        @(negedge clk);
        check("midrst_out0", out0, 32'h0);
        check("midrst_done", {31'b0, done}, 32'h1);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            in0     = $urandom;
            running = 1'($urandom);
        end
        check("postrst_out0", out0, 32'h0);
        check("postrst_done", {31'b0, done}, 32'h1);

        // All-ones block, delay 1
        drive_block(ones, 1, -1, 0, -1, r);
        check("ones_w16", log_out[r+20], 32'h203F_FFFC);
        for (int t = 0; t < 64; t++) check("ones_word", log_out[r+4+t], w_ones[t]);

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
